// File: rtl/keypad_scanner.sv
// keypad_scanner: matrix keypad scanner for the calculator front end.
// Drives one column at a time for SCAN_DIV clocks and synchronises the row
// lines. Key hits are accumulated over a full scan frame, the frame is
// debounced against the previous frames, and a one-cycle key event with a
// binary key code is produced, with optional typematic auto-repeat.
//
// Ports:
//   clk        - system clock
//   rst        - synchronous active-high reset
//   rows       - row sense lines, active-high, asynchronous to clk
//   cols       - one-hot active-high column drive
//   key_valid  - one-cycle pulse per accepted press or repeat
//   key_code   - key index = col*ROWS + row, held until the next accept
//   key_held   - high while an accepted key is considered down
//   multi_err  - one-cycle pulse after any frame in which 2+ keys were seen
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no key down, waiting for a single-key frame
// DEB_PRESS | candidate key seen, counting identical frames
// PRESSED   | key accepted, counting frames for auto-repeat
// DEB_REL   | empty frames seen after a press, counting toward release
module keypad_scanner #(
  parameter int ROWS        = 4,
  parameter int COLS        = 4,
  parameter int SCAN_DIV    = 1000,
  parameter int DEBOUNCE    = 4,
  parameter int REPEAT_DLY  = 0,
  parameter int REPEAT_RATE = 1,
  localparam int CODE_W     = $clog2(ROWS*COLS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ROWS-1:0]   rows,
  output logic [COLS-1:0]   cols,
  output logic              key_valid,
  output logic [CODE_W-1:0] key_code,
  output logic              key_held,
  output logic              multi_err
);

  localparam int DW_W    = $clog2(SCAN_DIV);
  localparam int COL_W   = $clog2(COLS);
  localparam int DEB_W   = $clog2(DEBOUNCE + 1);
  localparam int REP_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  typedef enum logic [1:0] {IDLE, DEB_PRESS, PRESSED, DEB_REL} state_t;

  state_t            state;
  logic [DW_W-1:0]   dwell;
  logic [COL_W-1:0]  col_idx;
  logic [ROWS-1:0]   rows_meta, rows_sync;
  logic [1:0]        acc_cnt;
  logic [CODE_W-1:0] acc_code;
  logic [CODE_W-1:0] cand;
  logic [DEB_W-1:0]  cnt;
  logic [REP_W-1:0]  rep_cnt;
  logic              rep_first;

  logic              sample, frame_end;
  logic [1:0]        col_hits, frame_cnt;
  logic [2:0]        hit_sum;
  logic [CODE_W-1:0] col_code, frame_code;
  logic [DEB_W-1:0]  cnt_inc;
  logic [REP_W-1:0]  rep_inc, rep_target;
  logic              is_none, is_single, is_multi;

  assign sample    = (dwell == DW_W'(SCAN_DIV - 1));
  assign frame_end = sample && (col_idx == COL_W'(COLS - 1));

  // Per-column hit count saturates at 2; when only one key is present in the
  // whole frame, whichever code was recorded is that key's code.
  always_comb begin
    col_hits = '0;
    col_code = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (rows_sync[r]) begin
        if (col_hits != 2'd2) col_hits = col_hits + 2'd1;
        col_code = CODE_W'(int'(col_idx) * ROWS + r);
      end
    end
    hit_sum    = {1'b0, acc_cnt} + {1'b0, col_hits};
    frame_cnt  = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    frame_code = (col_hits != 2'd0) ? col_code : acc_code;
  end

  assign is_none    = (frame_cnt == 2'd0);
  assign is_single  = (frame_cnt == 2'd1);
  assign is_multi   = (frame_cnt == 2'd2);
  assign cnt_inc    = cnt + DEB_W'(1);
  assign rep_inc    = rep_cnt + REP_W'(1);
  assign rep_target = rep_first ? REP_W'(REPEAT_RATE) : REP_W'(REPEAT_DLY);

  always_ff @(posedge clk) begin
    if (rst) begin
      dwell     <= '0;
      col_idx   <= '0;
      cols      <= COLS'(1);
      rows_meta <= '0;
      rows_sync <= '0;
      acc_cnt   <= '0;
      acc_code  <= '0;
    end else begin
      rows_meta <= rows;
      rows_sync <= rows_meta;
      if (sample) begin
        dwell   <= '0;
        cols    <= {cols[COLS-2:0], cols[COLS-1]};
        col_idx <= (col_idx == COL_W'(COLS - 1)) ? '0 : col_idx + COL_W'(1);
      end else begin
        dwell <= dwell + DW_W'(1);
      end
      if (frame_end) begin
        acc_cnt  <= '0;
        acc_code <= '0;
      end else if (sample) begin
        acc_cnt  <= frame_cnt;
        acc_code <= frame_code;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cand      <= '0;
      cnt       <= '0;
      rep_cnt   <= '0;
      rep_first <= 1'b0;
      key_valid <= 1'b0;
      key_code  <= '0;
      key_held  <= 1'b0;
      multi_err <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      multi_err <= 1'b0;
      if (frame_end) begin
        multi_err <= is_multi;
        case (state)
          IDLE: begin
            if (is_single) begin
              if (DEBOUNCE == 1) begin
                key_code  <= frame_code;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                rep_cnt   <= '0;
                rep_first <= 1'b0;
                state     <= PRESSED;
              end else begin
                cand  <= frame_code;
                cnt   <= DEB_W'(1);
                state <= DEB_PRESS;
              end
            end
          end
          DEB_PRESS: begin
            if (!is_single) begin
              state <= IDLE;
            end else if (frame_code != cand) begin
              cand <= frame_code;
              cnt  <= DEB_W'(1);
            end else if (cnt_inc == DEB_W'(DEBOUNCE)) begin
              key_code  <= cand;
              key_valid <= 1'b1;
              key_held  <= 1'b1;
              rep_cnt   <= '0;
              rep_first <= 1'b0;
              state     <= PRESSED;
            end else begin
              cnt <= cnt_inc;
            end
          end
          PRESSED: begin
            if (is_none) begin
              if (DEBOUNCE == 1) begin
                key_held <= 1'b0;
                state    <= IDLE;
              end else begin
                cnt   <= DEB_W'(1);
                state <= DEB_REL;
              end
            end else if (REPEAT_DLY > 0) begin
              // A different single key counts as the same key still down.
              if (rep_inc == rep_target) begin
                key_valid <= 1'b1;
                rep_cnt   <= '0;
                rep_first <= 1'b1;
              end else begin
                rep_cnt <= rep_inc;
              end
            end
          end
          DEB_REL: begin
            if (!is_none) begin
              state <= PRESSED;
            end else if (cnt_inc == DEB_W'(DEBOUNCE)) begin
              key_held <= 1'b0;
              state    <= IDLE;
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;
  localparam int ROWS = 4, COLS = 4, SCAN_DIV = 4, DEBOUNCE = 2;
  localparam int REPEAT_DLY = 3, REPEAT_RATE = 2;
  localparam int FRAME = COLS * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  rows, cols, key_code;
  logic        key_valid, key_held, multi_err;
  logic [15:0] pressed = '0;

  int n_checks = 0;
  int n_fail   = 0;

  logic       f_vld_end, f_vld_mid, f_merr_end, f_merr_mid, f_held;
  logic [3:0] f_code;

  always #5 clk = ~clk;

  keypad_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE),
    .REPEAT_DLY(REPEAT_DLY), .REPEAT_RATE(REPEAT_RATE)
  ) dut (
    .clk(clk), .rst(rst), .rows(rows), .cols(cols),
    .key_valid(key_valid), .key_code(key_code),
    .key_held(key_held), .multi_err(multi_err)
  );

  // Keypad model: a pressed key connects its column drive to its row line.
  always_comb begin
    rows = '0;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        if (pressed[c*ROWS + r] && cols[c]) rows[r] = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One scan frame with a fixed key set; results of this frame's end are
  // visible at the last sample (1 clk after the frame-end edge).
  task automatic run_frame(input logic [15:0] keys);
    pressed    = keys;
    f_vld_mid  = 1'b0;
    f_merr_mid = 1'b0;
    for (int i = 1; i <= FRAME; i++) begin
      @(posedge clk);
      #1;
      if (i < FRAME) begin
        f_vld_mid  = f_vld_mid | key_valid;
        f_merr_mid = f_merr_mid | multi_err;
      end else begin
        f_vld_end  = key_valid;
        f_merr_end = multi_err;
        f_held     = key_held;
        f_code     = key_code;
      end
    end
  endtask

  initial begin
    // Reset and scan
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_cols", cols, 4'b0001);
    check("rst_valid", key_valid, 1'b0);
    check("rst_held", key_held, 1'b0);
    check("rst_code", key_code, 4'd0);
    check("rst_merr", multi_err, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 1; i <= FRAME; i++) begin
      @(posedge clk);
      #1;
      check("scan_cols", cols, 4'b0001 << ((i / SCAN_DIV) % COLS));
      check("scan_quiet", {key_valid, key_held, multi_err}, 3'b000);
    end

    // Clean press of key 9 (col 2, row 1)
    run_frame(16'h0200);
    check("press_f1_valid", f_vld_end, 1'b0);
    check("press_f1_held", f_held, 1'b0);
    run_frame(16'h0200);
    check("press_f2_valid", f_vld_end, 1'b1);
    check("press_f2_code", f_code, 4'd9);
    check("press_f2_held", f_held, 1'b1);
    check("press_f2_mid", f_vld_mid, 1'b0);
    run_frame(16'h0200);
    check("press_f3_valid", f_vld_end | f_vld_mid, 1'b0);
    run_frame(16'h0200);
    check("press_f4_valid", f_vld_end | f_vld_mid, 1'b0);
    run_frame(16'h0000);
    check("rel_f1_held", f_held, 1'b1);
    check("rel_f1_valid", f_vld_end, 1'b0);
    run_frame(16'h0000);
    check("rel_f2_held", f_held, 1'b0);
    check("rel_f2_code", f_code, 4'd9);
    check("rel_f2_valid", f_vld_end, 1'b0);

    // Bounce: present, absent, present, present
    run_frame(16'h0200);
    check("bounce_f1_valid", f_vld_end, 1'b0);
    run_frame(16'h0000);
    check("bounce_f2_valid", f_vld_end, 1'b0);
    run_frame(16'h0200);
    check("bounce_f3_valid", f_vld_end, 1'b0);
    run_frame(16'h0200);
    check("bounce_f4_valid", f_vld_end, 1'b1);
    check("bounce_f4_code", f_code, 4'd9);
    run_frame(16'h0000);
    run_frame(16'h0000);
    check("bounce_rel_held", f_held, 1'b0);

    // Multi-key: keys 0 and 5
    for (int f = 0; f < 3; f++) begin
      run_frame(16'h0021);
      check("multi_err_end", f_merr_end, 1'b1);
      check("multi_err_mid", f_merr_mid, 1'b0);
      check("multi_valid", f_vld_end | f_vld_mid, 1'b0);
      check("multi_held", f_held, 1'b0);
    end
    run_frame(16'h0000);
    check("multi_clear", f_merr_end, 1'b0);

    // Auto-repeat on key 10: events after frames 2, 5, 7, 9
    run_frame(16'h0400);
    check("rep_f1_valid", f_vld_end, 1'b0);
    run_frame(16'h0400);
    check("rep_f2_valid", f_vld_end, 1'b1);
    check("rep_f2_code", f_code, 4'd10);
    run_frame(16'h0400);
    check("rep_f3_valid", f_vld_end, 1'b0);
    run_frame(16'h0400);
    check("rep_f4_valid", f_vld_end, 1'b0);
    run_frame(16'h0400);
    check("rep_f5_valid", f_vld_end, 1'b1);
    check("rep_f5_code", f_code, 4'd10);
    run_frame(16'h0400);
    check("rep_f6_valid", f_vld_end, 1'b0);
    run_frame(16'h0400);
    check("rep_f7_valid", f_vld_end, 1'b1);
    run_frame(16'h0400);
    check("rep_f8_valid", f_vld_end, 1'b0);
    run_frame(16'h0400);
    check("rep_f9_valid", f_vld_end, 1'b1);
    check("rep_f9_code", f_code, 4'd10);
    check("rep_f9_mid", f_vld_mid, 1'b0);
    run_frame(16'h0000);
    run_frame(16'h0000);
    check("rep_rel_held", f_held, 1'b0);
    check("rep_rel_code", f_code, 4'd10);

    // Reset while key 3 is held
    run_frame(16'h0008);
    run_frame(16'h0008);
    check("rstp_accept_valid", f_vld_end, 1'b1);
    check("rstp_accept_code", f_code, 4'd3);
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("rstp_held", key_held, 1'b0);
    check("rstp_code", key_code, 4'd0);
    check("rstp_cols", cols, 4'b0001);
    check("rstp_valid", key_valid, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    run_frame(16'h0008);
    check("rstp_f1_valid", f_vld_end | f_vld_mid, 1'b0);
    check("rstp_f1_held", f_held, 1'b0);
    run_frame(16'h0008);
    check("rstp_f2_valid", f_vld_end, 1'b1);
    check("rstp_f2_code", f_code, 4'd3);
    check("rstp_f2_held", f_held, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Parametrised matrix-keypad scanner with ROWS x COLS keys; successor to the fixed 4x4 ring-counter scanner.
- Drives one-hot active-high columns with a programmable dwell time and synchronises the row inputs.
- Debounces over whole scan frames, rejects multi-key frames, and emits a single-cycle key event with a binary key code, plus optional typematic auto-repeat.
- Sits between the keypad pins and the calculator input FSM.

Parameters:
- ROWS, 4, number of row inputs (>=1).
- COLS, 4, number of column outputs (>=2).
- SCAN_DIV, 1000, clocks each column is driven (>=4).
- DEBOUNCE, 4, consecutive identical frames required to accept a press or a release (>=1).
- REPEAT_DLY, 0, frames held after acceptance before the first repeat; 0 disables repeat.
- REPEAT_RATE, 1, frames between subsequent repeats (>=1).

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset; synchronous, active-high.
- rows, input, ROWS, row sense lines, active-high, asynchronous to clk.
- cols, output, COLS, one-hot active-high column drive.
- key_valid, output, 1, one-cycle pulse per accepted press or repeat.
- key_code, output, CODE_W = $clog2(ROWS*COLS), key index = col*ROWS + row.
- key_held, output, 1, high while an accepted key is considered down.
- multi_err, output, 1, one-cycle pulse at the end of any frame in which 2 or more keys were seen.

Behaviour:
- Reset values:
  - cols = 1 (column 0 driven).
  - key_valid = 0, key_code = 0, key_held = 0, multi_err = 0.
  - Dwell counter, frame accumulators and repeat counter = 0.
  - FSM state = IDLE.
- Reset has priority over all other activity, including mid-frame and mid-PRESSED. After rst is released, a held key must be re-debounced from scratch.
- Column scan:
  - The dwell counter runs 0..SCAN_DIV-1; cols rotates left on wrap (col COLS-1 wraps to col 0).
  - A frame is COLS*SCAN_DIV clocks.
  - Frame end is the last dwell cycle of column COLS-1.
- Row capture:
  - rows pass through a 2-FF synchroniser.
  - The synchronised value is sampled on the last dwell cycle of each column.
- Per-frame accumulation:
  - Each set bit (col c, row r) increments a saturating press count (saturates at 2) and records code c*ROWS+r.
  - At frame end the frame is classified as NONE (0 keys), SINGLE(code) (1 key) or MULTI (2 or more keys). The accumulators then clear.
- FSM, evaluated once per frame end:
  - IDLE:
    - SINGLE(k): candidate=k, cnt=1, go to DEB_PRESS. If DEBOUNCE=1, accept immediately instead.
  - DEB_PRESS:
    - SINGLE(same k): cnt++. When cnt reaches DEBOUNCE, accept.
    - SINGLE(different k): candidate=k, cnt=1.
    - NONE or MULTI: go to IDLE.
  - Accept:
    - key_code<=candidate; key_valid pulses in the cycle after frame end.
    - key_held<=1; repeat counter=0; go to PRESSED.
  - PRESSED:
    - SINGLE(same k) or MULTI: key still down. If REPEAT_DLY>0, increment the repeat counter.
      - When the counter reaches REPEAT_DLY (first repeat), or REPEAT_RATE (later repeats), pulse key_valid with the unchanged key_code and reset the counter.
    - NONE: relcnt=1, go to DEB_REL. If DEBOUNCE=1, release immediately.
    - SINGLE(different k): treated as still down; no new event until a full release.
  - DEB_REL:
    - NONE: relcnt++. At DEBOUNCE, key_held<=0 and go to IDLE.
    - Any key present: return to PRESSED; the repeat counter is preserved.
- multi_err:
  - Pulses in the cycle after every MULTI frame end, in any state.
  - Never coincides with an accepted press from the same frame.
- key_code holds its value until the next accept; it does not change on release.
- Latency: a press stable from frame n is reported 1 clk after the end of frame n+DEBOUNCE-1, provided it was present before that frame's sample point.

Test Plan (ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE=2, frame=16 clk unless noted):
- Reset and scan: hold rst 3 clk, then release -> cols=0001 during reset; after release cols steps 0001->0010->0100->1000->0001 every 4 clk; all other outputs stay 0.
- Clean press: assert row1 during col2 (code 9) for 4 frames, then release -> exactly one key_valid pulse, 1 clk after frame 2 end, with key_code=9; key_held falls 1 clk after the 2nd empty frame end; key_code stays 9.
- Bounce: key 9 present in frame 1, absent in frame 2, present in frames 3-4 -> no pulse after frame 1; single key_valid after frame 4 end.
- Multi-key: keys 0 and 5 held for 3 frames -> multi_err pulses after each frame end; key_valid and key_held stay 0.
- Repeat (REPEAT_DLY=3, REPEAT_RATE=2): hold key 10 for 9 frames -> key_valid pulses after the ends of frames 2, 5, 7 and 9, with key_code=10 each time.
- Reset mid-press: key 3 accepted, then rst pulsed while key stays down -> outputs clear immediately; a fresh key_valid with key_code=3 follows after 2 full frames post-reset.
